// File: rtl/uart_cmd_bridge_pkg.sv
// Shared constants and FSM encoding for the UART command bridge.
// ST_CHK exists only when UART_BRIDGE_CHKSUM_EN is defined.
package uart_cmd_bridge_pkg;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CMD_WR    = 8'h01;
   localparam logic [7:0] CMD_RD    = 8'h02;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
`ifdef UART_BRIDGE_CHKSUM_EN
      ST_CHK,
`endif
      ST_EXEC,
      ST_RESP
   } state_t;
endpackage

// File: rtl/uart_cmd_bridge_if.sv
// Byte streams (rx/tx), peripheral bus and error pulse of the bridge.
// master = bridge side, slave = UART/bus environment side.
interface uart_cmd_bridge_if #(parameter int ADDR_WIDTH = 32);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [31:0]           bus_wdata;
   logic                  bus_we;
   logic                  bus_re;
   logic [31:0]           bus_rdata;
   logic                  frame_err;

   modport master (
      input  rx_data, rx_valid, tx_ready, bus_rdata,
      output rx_ready, tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, frame_err
   );
   modport slave (
      output rx_data, rx_valid, tx_ready, bus_rdata,
      input  rx_ready, tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, frame_err
   );
endinterface

// File: rtl/uart_bridge_resp_ser.sv
// Response serialiser: header byte, optionally followed by a 32-bit word LE,
// each byte held on tx_data until accepted.
module uart_bridge_resp_ser (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [7:0]  hdr,
   input  logic        len5,
   input  logic [31:0] word,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);
   logic [31:0] sh;
   logic [2:0]  left;

   assign done = tx_valid && tx_ready && (left == 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         sh       <= 32'h0;
         left     <= 3'd0;
      end else if (load) begin
         tx_valid <= 1'b1;
         tx_data  <= hdr;
         sh       <= word;
         left     <= len5 ? 3'd4 : 3'd0;
      end else if (tx_valid && tx_ready) begin
         if (left == 3'd0) begin
            tx_valid <= 1'b0;
         end else begin
            tx_data <= sh[7:0];
            sh      <= {8'h00, sh[31:8]};
            left    <= left - 3'd1;
         end
      end
   end
endmodule

// File: rtl/uart_cmd_bridge.sv
// UART byte-stream to peripheral-bus command bridge (single 32-bit rd/wr).
// Define UART_BRIDGE_CHKSUM_EN to require and check the trailing XOR byte.
module uart_cmd_bridge
   import uart_cmd_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_cmd_bridge_if.master bif
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state;
   logic [1:0]    bcnt;
   logic          is_wr;
   logic [31:0]   addr_sh;
   logic [31:0]   addr_nxt;
   logic [31:0]   data_nxt;
   logic [TW-1:0] to_cnt;
   logic          acc, in_frame;
   logic          ser_load, ser_len5, ser_done;
   logic [7:0]    ser_hdr;
   logic [31:0]   ser_word;

`ifdef UART_BRIDGE_CHKSUM_EN
   logic [7:0]  xor_acc;
   logic [31:0] data_sh;
   assign data_nxt = {bif.rx_data, data_sh[31:8]};
`else
   // Last data byte is taken straight from rx_data, so only 3 bytes are stored.
   logic [23:0] data_sh;
   assign data_nxt = {bif.rx_data, data_sh};
`endif

   assign addr_nxt     = {bif.rx_data, addr_sh[31:8]};
   assign bif.rx_ready = (state != ST_EXEC) && (state != ST_RESP);
   assign acc          = bif.rx_valid && bif.rx_ready;
   assign in_frame     = bif.rx_ready && (state != ST_SYNC);

   always_comb begin
      ser_load = 1'b0;
      ser_hdr  = RSP_NAK;
      ser_len5 = 1'b0;
      ser_word = 32'h0;
      if (state == ST_EXEC) begin
         ser_load = 1'b1;
         ser_hdr  = RSP_ACK;
         ser_len5 = !is_wr;
         ser_word = bif.bus_rdata;
      end else if (acc && state == ST_CMD && bif.rx_data != CMD_WR && bif.rx_data != CMD_RD) begin
         ser_load = 1'b1;
      end
`ifdef UART_BRIDGE_CHKSUM_EN
      else if (acc && state == ST_CHK && bif.rx_data != xor_acc) begin
         ser_load = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_SYNC;
         bcnt          <= 2'd0;
         is_wr         <= 1'b0;
         addr_sh       <= 32'h0;
         data_sh       <= '0;
         to_cnt        <= '0;
         bif.bus_addr  <= '0;
         bif.bus_wdata <= 32'h0;
         bif.bus_we    <= 1'b0;
         bif.bus_re    <= 1'b0;
         bif.frame_err <= 1'b0;
`ifdef UART_BRIDGE_CHKSUM_EN
         xor_acc       <= 8'h00;
`endif
      end else begin
         bif.bus_we    <= 1'b0;
         bif.bus_re    <= 1'b0;
         bif.frame_err <= 1'b0;
         to_cnt        <= '0;
`ifdef UART_BRIDGE_CHKSUM_EN
         if (acc && state != ST_SYNC && state != ST_CHK) xor_acc <= xor_acc ^ bif.rx_data;
`endif
         // Idle gap inside a frame: abandon it silently apart from frame_err.
         if (in_frame && !acc && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state         <= ST_SYNC;
            bif.frame_err <= 1'b1;
         end else begin
            if (in_frame && !acc) to_cnt <= to_cnt + 1'b1;
            case (state)
               ST_SYNC: if (acc && bif.rx_data == SYNC_BYTE) begin
                  state <= ST_CMD;
`ifdef UART_BRIDGE_CHKSUM_EN
                  xor_acc <= 8'h00;
`endif
               end
               ST_CMD: if (acc) begin
                  bcnt <= 2'd0;
                  if (bif.rx_data == CMD_WR || bif.rx_data == CMD_RD) begin
                     is_wr <= (bif.rx_data == CMD_WR);
                     state <= ST_ADDR;
                  end else begin
                     state         <= ST_RESP;
                     bif.frame_err <= 1'b1;
                  end
               end
               ST_ADDR: if (acc) begin
                  addr_sh <= addr_nxt;
                  bcnt    <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     if (is_wr) state <= ST_DATA;
                     else begin
`ifdef UART_BRIDGE_CHKSUM_EN
                        state <= ST_CHK;
`else
                        state        <= ST_EXEC;
                        bif.bus_re   <= 1'b1;
                        bif.bus_addr <= addr_nxt[ADDR_WIDTH-1:0];
`endif
                     end
                  end
               end
               ST_DATA: if (acc) begin
                  data_sh <= data_nxt[31 -: $bits(data_sh)];
                  bcnt    <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
`ifdef UART_BRIDGE_CHKSUM_EN
                     state <= ST_CHK;
`else
                     state         <= ST_EXEC;
                     bif.bus_we    <= 1'b1;
                     bif.bus_addr  <= addr_sh[ADDR_WIDTH-1:0];
                     bif.bus_wdata <= data_nxt;
`endif
                  end
               end
`ifdef UART_BRIDGE_CHKSUM_EN
               ST_CHK: if (acc) begin
                  if (bif.rx_data == xor_acc) begin
                     state        <= ST_EXEC;
                     bif.bus_we   <= is_wr;
                     bif.bus_re   <= !is_wr;
                     bif.bus_addr <= addr_sh[ADDR_WIDTH-1:0];
                     if (is_wr) bif.bus_wdata <= data_sh;
                  end else begin
                     state         <= ST_RESP;
                     bif.frame_err <= 1'b1;
                  end
               end
`endif
               ST_EXEC: state <= ST_RESP;
               ST_RESP: if (ser_done) state <= ST_SYNC;
               default: state <= ST_SYNC;
            endcase
         end
      end
   end

   uart_bridge_resp_ser u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ser_load),
      .hdr      (ser_hdr),
      .len5     (ser_len5),
      .word     (ser_word),
      .tx_data  (bif.tx_data),
      .tx_valid (bif.tx_valid),
      .tx_ready (bif.tx_ready),
      .done     (ser_done)
   );
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge; frames gain a CHK byte when
// UART_BRIDGE_CHKSUM_EN is defined.
module tb_uart_cmd_bridge;
   localparam int TO = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_bridge_if #(.ADDR_WIDTH(32)) bif ();
   uart_cmd_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif.master)
   );

   int total = 0, bad = 0;
   int we_cnt = 0, re_cnt = 0, fe_cnt = 0, stall_viol = 0;
   logic [31:0] we_addr = 0, we_data = 0, re_addr = 0;
   logic [7:0]  txq[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   always @(negedge clk) begin
      if (bif.bus_we) begin we_cnt++; we_addr = bif.bus_addr; we_data = bif.bus_wdata; end
      if (bif.bus_re) begin re_cnt++; re_addr = bif.bus_addr; end
      if (bif.frame_err) fe_cnt++;
      if (bif.tx_valid && bif.tx_ready) txq.push_back(bif.tx_data);
      if (prev_stall && bif.tx_data !== prev_data) stall_viol++;
      prev_stall = bif.tx_valid && !bif.tx_ready;
      prev_data  = bif.tx_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a posedge; returns just after the edge that accepted b.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      while (!bif.rx_ready && n < 1000) begin @(negedge clk); n++; end
      if (n >= 1000) check("rx_accept_bound", 32'(n), 32'd0);
      @(posedge clk); #1;
      bif.rx_valid = 1'b0;
   endtask

   task automatic send_q(input logic [7:0] q[$]);
      foreach (q[i]) send_byte(q[i]);
   endtask

   task automatic wait_tx(input string tag, input int n);
      int k = 0;
      while (txq.size() < n && k < 2000) begin @(posedge clk); #1; k++; end
      repeat (3) begin @(posedge clk); #1; end
      check(tag, 32'(txq.size()), 32'(n));
   endtask

   task automatic check_rd_resp(input string tag, input int base);
      logic [7:0] exp_b[5] = '{8'h06, 8'h78, 8'h56, 8'h34, 8'h12};
      for (int i = 0; i < 5; i++)
         check(tag, (txq.size() > base + i) ? {24'h0, txq[base + i]} : 32'hFFFF_FFFF, {24'h0, exp_b[i]});
   endtask

   logic [7:0] fr[$];
   logic [7:0] rd_fr[$];
   int n0, w0, r0, f0, k, rdy_viol;

   initial begin
      bif.rx_data   = 8'h00;
      bif.rx_valid  = 1'b0;
      bif.tx_ready  = 1'b1;
      bif.bus_rdata = 32'h1234_5678;
      rd_fr = {8'hA5, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00};
`ifdef UART_BRIDGE_CHKSUM_EN
      rd_fr.push_back(8'h06);
`endif
      #12;
      check("rst_rx_ready", bif.rx_ready, 1);
      check("rst_tx_valid", bif.tx_valid, 0);
      check("rst_tx_data", bif.tx_data, 0);
      check("rst_bus_we", bif.bus_we, 0);
      check("rst_bus_re", bif.bus_re, 0);
      check("rst_bus_addr", bif.bus_addr, 0);
      check("rst_bus_wdata", bif.bus_wdata, 0);
      check("rst_frame_err", bif.frame_err, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // write: strobe one cycle after last byte, ACK one cycle after EXEC
      fr = {8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_BRIDGE_CHKSUM_EN
      fr.push_back(8'h33);
`endif
      send_q(fr);
      check("wr_we", bif.bus_we, 1);
      check("wr_addr", bif.bus_addr, 32'h10);
      check("wr_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
      check("wr_rx_ready_exec", bif.rx_ready, 0);
      @(posedge clk); #1;
      check("wr_we_pulse", bif.bus_we, 0);
      check("wr_tx_valid", bif.tx_valid, 1);
      check("wr_tx_ack", bif.tx_data, 8'h06);
      @(posedge clk); #1;
      check("wr_tx_drop", bif.tx_valid, 0);
      check("wr_rx_ready_back", bif.rx_ready, 1);
      check("wr_we_cnt", 32'(we_cnt), 1);
      check("wr_re_cnt", 32'(re_cnt), 0);
      check("wr_tx_len", 32'(txq.size()), 1);
      check("wr_fe_cnt", 32'(fe_cnt), 0);

      // read
      n0 = txq.size();
      send_q(rd_fr);
      check("rd_re", bif.bus_re, 1);
      check("rd_addr", bif.bus_addr, 32'h4);
      check("rd_wdata_hold", bif.bus_wdata, 32'hDEAD_BEEF);
      wait_tx("rd_tx_len", n0 + 5);
      check_rd_resp("rd_tx_byte", n0);
      check("rd_re_cnt", 32'(re_cnt), 1);
      check("rd_we_cnt", 32'(we_cnt), 1);

`ifdef UART_BRIDGE_CHKSUM_EN
      // bad checksum
      n0 = txq.size(); w0 = we_cnt; f0 = fe_cnt;
      fr[10] = 8'h34;
      send_q(fr);
      check("chk_frame_err", bif.frame_err, 1);
      wait_tx("chk_tx_len", n0 + 1);
      check("chk_nak", {24'h0, txq[n0]}, 32'h15);
      check("chk_no_we", 32'(we_cnt), 32'(w0));
      check("chk_fe_cnt", 32'(fe_cnt), 32'(f0 + 1));
`endif

      // sync filtering and unknown CMD
      n0 = txq.size(); w0 = we_cnt; r0 = re_cnt; f0 = fe_cnt;
      fr = {8'h00, 8'hFF, 8'hA5, 8'h07};
      send_q(fr);
      check("cmd_frame_err", bif.frame_err, 1);
      wait_tx("cmd_tx_len", n0 + 1);
      check("cmd_nak", {24'h0, txq[n0]}, 32'h15);
      check("cmd_no_bus", 32'(we_cnt + re_cnt), 32'(w0 + r0));
      check("cmd_fe_cnt", 32'(fe_cnt), 32'(f0 + 1));
      n0 = txq.size();
      send_q(rd_fr);
      wait_tx("cmd_rd_tx_len", n0 + 5);
      check_rd_resp("cmd_rd_byte", n0);

      // timeout: frame_err exactly TO cycles after the last accepted byte
      n0 = txq.size(); r0 = re_cnt;
      fr = {8'hA5, 8'h02, 8'h04};
      send_q(fr);
      k = 0;
      while (!bif.frame_err && k < 4 * TO) begin @(posedge clk); #1; k++; end
      check("to_cycles", 32'(k), 32'(TO));
      repeat (5) begin @(posedge clk); #1; end
      check("to_no_tx", 32'(txq.size()), 32'(n0));
      check("to_no_re", 32'(re_cnt), 32'(r0));
      check("to_rx_ready", bif.rx_ready, 1);
      send_q(rd_fr);
      wait_tx("to_rd_tx_len", n0 + 5);
      check_rd_resp("to_rd_byte", n0);

      // backpressure on every response byte
      n0 = txq.size(); rdy_viol = 0;
      bif.tx_ready = 1'b0;
      send_q(rd_fr);
      for (int i = 0; i < 5; i++) begin
         k = 0;
         while (!bif.tx_valid && k < 20) begin @(posedge clk); #1; k++; end
         repeat (50) begin @(posedge clk); #1; if (bif.rx_ready) rdy_viol++; end
         bif.tx_ready = 1'b1;
         @(posedge clk); #1;
         bif.tx_ready = 1'b0;
         if (i < 4) begin
            if (bif.rx_ready) rdy_viol++;
         end
      end
      check("bp_tx_drop", bif.tx_valid, 0);
      check("bp_rx_ready_back", bif.rx_ready, 1);
      check("bp_rx_ready_held", 32'(rdy_viol), 0);
      check("bp_tx_stable", 32'(stall_viol), 0);
      bif.tx_ready = 1'b1;
      wait_tx("bp_tx_len", n0 + 5);
      check_rd_resp("bp_byte", n0);

      // reset mid-frame
      w0 = we_cnt;
      fr = {8'hA5, 8'h01, 8'h10};
      send_q(fr);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rx_ready", bif.rx_ready, 1);
      check("mid_rst_bus_addr", bif.bus_addr, 0);
      check("mid_rst_bus_wdata", bif.bus_wdata, 0);
      check("mid_rst_tx_valid", bif.tx_valid, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      n0 = txq.size();
      send_q(rd_fr);
      wait_tx("mid_rst_rd_tx_len", n0 + 5);
      check_rd_resp("mid_rst_rd_byte", n0);
      check("mid_rst_no_we", 32'(we_cnt), 32'(w0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_cmd_bridge.md
# uart_cmd_bridge

Byte-stream command bridge that sits directly downstream of the UART receive path and upstream of its transmit path. It parses binary command frames from received bytes, performs single 32-bit read or write accesses on the peripheral bus, and returns acknowledge and response bytes for transmission. It gives a host PC debug and boot-load access to memory-mapped registers over the serial link.

## Interface
- `ADDR_WIDTH`, 32: bus address width. Frames always carry 4 address bytes; upper bytes beyond `ADDR_WIDTH` are discarded.
- `TIMEOUT_CYCLES`, 1_000_000: maximum clk cycles allowed between accepted bytes inside a frame.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  bridge accepts a byte this cycle.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts `tx_data`.
- `bus_addr`  out  ADDR_WIDTH  access address.
- `bus_wdata`  out  32  write data.
- `bus_we`  out  1  write strobe, single-cycle pulse.
- `bus_re`  out  1  read strobe, single-cycle pulse.
- `bus_rdata`  in  32  read data, valid combinationally in the same cycle as `bus_re`.
- `frame_err`  out  1  one-cycle pulse on a NAK or a timeout.

## Operation
- Frame format: `0xA5` sync, CMD, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], then WDATA as 4 bytes LE (write only), then CHK.
- CMD `0x01` is write. CMD `0x02` is read.
- Responses:
  - Write OK: `0x06`.
  - Read OK: `0x06` followed by RDATA as 4 bytes LE.
  - Error: `0x15` (NAK).
- A byte is transferred only when `rx_valid && rx_ready`.
- `rx_ready` = 1 only in states SYNC, CMD, ADDR, DATA and CHK.
- FSM states and transitions:
  - SYNC: a byte ≠ `0xA5` is dropped silently. `0xA5` goes to CMD.
  - CMD: `0x01` or `0x02` is stored and goes to ADDR. Any other value goes to RESP with a NAK, and no further bytes are consumed.
  - ADDR: collects 4 bytes using a 2-bit byte counter. Then write goes to DATA, read goes to CHK.
  - DATA: collects 4 bytes, then goes to CHK.
  - CHK: the received byte is compared with the running XOR of every byte after sync. Match goes to EXEC. Mismatch goes to RESP with a NAK, and no bus access is made.
  - EXEC: exactly one cycle. Asserts `bus_we` or `bus_re`. On read, `bus_rdata` is captured in the same cycle. Then goes to RESP.
  - RESP: sends 1 or 5 bytes in order. Each byte is held until `tx_valid && tx_ready`. After the last byte, goes to SYNC.
- Timeout: a counter runs in states CMD through CHK and resets on each accepted byte. On reaching `TIMEOUT_CYCLES - 1` the partial frame is discarded, `frame_err` pulses, the FSM goes to SYNC, and no response is sent.
- `0xA5` received mid-frame is treated as ordinary data; there is no resync.
- `bus_addr` and `bus_wdata` hold their last values between accesses.

## Timing
- Reset values:
  - `rx_ready` 1 (SYNC).
  - `tx_valid` 0, `tx_data` 0x00.
  - `bus_we` 0, `bus_re` 0, `bus_addr` 0, `bus_wdata` 0.
  - `frame_err` 0.
- Bus strobe fires 1 cycle after the last frame byte is accepted.
- The first response byte is presented with `tx_valid` 1 cycle after EXEC.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- `tx_valid` drops in the cycle after the last handshake. `rx_ready` rises in that same cycle.
- Reset asserted mid-frame or mid-response: the frame is lost, no partial bus access occurs, and all outputs return to their reset values immediately.

## Configuration
- `UART_BRIDGE_CHKSUM_EN` defined: the CHK byte is required and checked as above.
- `UART_BRIDGE_CHKSUM_EN` undefined: there is no CHK state and no XOR logic. The last ADDR byte (read) or DATA byte (write) goes directly to EXEC. The only source of NAK is an unknown CMD.

## Structure
- Shared package holds:
  - Constants `SYNC_BYTE` = 0xA5, `CMD_WR` = 0x01, `CMD_RD` = 0x02, `RSP_ACK` = 0x06, `RSP_NAK` = 0x15.
  - The FSM state encoding.
- One natural sub-module, `uart_bridge_resp_ser`: loads a response length (1 or 5) plus a 32-bit word and serialises bytes under the valid/ready handshake.

## Test plan
- Write with checksum: A5 01 10 00 00 00 EF BE AD DE 33 -> one-cycle `bus_we` with `bus_addr` = 0x00000010 and `bus_wdata` = 0xDEADBEEF; tx 06.
- Read: A5 02 04 00 00 00 06 with `bus_rdata` = 0x12345678 -> one-cycle `bus_re` with `bus_addr` = 0x04; tx 06 78 56 34 12.
- Bad checksum: write frame from the first scenario with CHK = 0x34 -> no bus strobe; tx 15; `frame_err` pulse.
- Unknown CMD and sync filtering:
  - 00 FF A5 07 -> the first two bytes are dropped, no bus access, tx 15.
  - A following valid read frame succeeds.
- Timeout: A5 02 04, then stall for `TIMEOUT_CYCLES` -> `frame_err` pulse, no tx. A subsequent full read frame gets a normal response.
- Backpressure:
  - During the read response, hold `tx_ready` = 0 for 50 cycles per byte -> byte order and values unchanged.
  - `rx_ready` stays 0 until the last byte is accepted.
